relu_activation: RTL and testbench
==================================

Name: relu_activation

Overview:
- Registered ReLU activation stage for the autoencoder datapath.
- Takes one signed fixed-point sample per accepted transfer and produces max(0, x).
- Optional leaky slope and optional upper clamp.
- Sits between a neuron MAC/accumulator output and the next layer's input buffer; uses valid/ready handshakes on both sides.

Parameters:
- NBITS, 16, data width; two's-complement signed, Q(NBITS-FRAC_BITS).FRAC_BITS.
- FRAC_BITS, 8, fractional bits. Informational: scales CLAMP_MAX, no arithmetic effect.
- LEAKY_SHIFT, 0, 0 = plain ReLU. N>0 = negative inputs map to val >>> N (arithmetic shift, truncation toward -inf).
- CLAMP_EN, 0, 1 = positive outputs saturate at CLAMP_MAX.
- CLAMP_MAX, 16'h0600, upper clamp (6.0 in Q8.8). Must be non-negative; used only when CLAMP_EN=1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  val holds a sample
- in_ready  out  1  stage can accept a sample this cycle
- val  in  NBITS  input sample, signed
- out_valid  out  1  result holds a valid output
- out_ready  in  1  downstream accepts result this cycle
- result  out  NBITS  activated sample, signed

Behaviour:
- Reset (async assert, release on clock edge): out_valid=0, result=0. in_ready=1 after reset.
- in_ready = !out_valid || out_ready. This is combinational; no combinational path from in_valid to in_ready.
- Input accept = in_valid && in_ready. On accept at a rising edge:
  - result <= f(val)
  - out_valid <= 1
- Latency: exactly 1 cycle from accept to out_valid.
- Throughput: 1 sample/cycle when out_ready is held high.
- Output transfer = out_valid && out_ready. If a transfer occurs and there is no simultaneous accept: out_valid <= 0, result holds its last value.
- Simultaneous transfer and accept in the same cycle: the new sample replaces the old one, out_valid stays 1, and no bubble is inserted.
- Backpressure: while out_valid=1 and out_ready=0, result and out_valid hold stable. in_ready=0, and val is ignored.
- f(x) definition:
  - If x[NBITS-1]=1 (negative): LEAKY_SHIFT=0 gives 0; otherwise x >>> LEAKY_SHIFT.
  - Else (zero or positive): if CLAMP_EN=1 and x > CLAMP_MAX, output CLAMP_MAX; otherwise output x.
  - Zero input gives zero output.
- Boundaries:
  - Most negative input (0x8000): 0 in plain mode; 0x8000>>>N in leaky mode.
  - 0x7FFF passes unchanged when CLAMP_EN=0.
  - An input equal to CLAMP_MAX passes unchanged.
- Reset mid-operation: any held output is discarded and out_valid drops to 0 immediately.
- Outputs are driven only from registers. No X propagation: result is reset to 0.

Test Plan:
- Plain mode, val=0xF900 (-7.0), one transfer with out_ready=1 -> one cycle later out_valid=1, result=0x0000.
- val=0x0300 (3.0) -> result=0x0300. Also val=0x0000 -> 0x0000. Also val=0x8000 -> 0x0000. Also val=0x7FFF -> 0x7FFF.
- Stream of 4 samples (0x0100, 0xFF00, 0x0200, 0x8001) with out_ready=1:
  - in_ready stays 1 throughout.
  - Outputs are 0x0100, 0x0000, 0x0200, 0x0000 on consecutive cycles.
- Backpressure: accept 0x0500, hold out_ready=0 for 3 cycles.
  - in_ready=0, and result stays 0x0500.
  - Changes to val are ignored.
  - out_ready=1 completes the transfer and the next sample is accepted in the same cycle.
- Parameter variants:
  - LEAKY_SHIFT=3: 0xF900 -> 0xFF20.
  - CLAMP_EN=1: 0x0700 -> 0x0600, and 0x0600 -> 0x0600.
- Reset asserted while out_valid=1 and out_ready=0 -> out_valid=0 and result=0 without waiting for a clock edge. After release, in_ready=1.

Source files
------------

// File: rtl/relu_activation.sv
// Registered ReLU stage with optional leaky slope and upper clamp.
// One-deep output register with valid/ready handshake on both sides.
module relu_activation #(
    parameter int unsigned      NBITS       = 16,
    parameter int unsigned      FRAC_BITS   = 8,
    parameter int unsigned      LEAKY_SHIFT = 0,
    parameter int unsigned      CLAMP_EN    = 0,
    parameter logic [NBITS-1:0] CLAMP_MAX   = 'h0600
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] result
);

    // FRAC_BITS only documents the fixed-point format; reject impossible formats.
    if (FRAC_BITS >= NBITS) begin : g_bad_frac
        $error("relu_activation: FRAC_BITS must be below NBITS");
    end
    if (CLAMP_MAX[NBITS-1]) begin : g_bad_clamp
        $error("relu_activation: CLAMP_MAX must be non-negative");
    end

    logic             accept;
    logic [NBITS-1:0] act;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Activation function: negative -> zero or arithmetic shift, positive -> optional clamp.
    always_comb begin
        act = val;
        if (val[NBITS-1]) begin
            if (LEAKY_SHIFT == 0) begin
                act = '0;
            end else begin
                act = NBITS'($signed(val) >>> LEAKY_SHIFT);
            end
        end else if ((CLAMP_EN != 0) && (val > CLAMP_MAX)) begin
            act = CLAMP_MAX;
        end
    end

    // Output register; result keeps its last value after a drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= act;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_relu_activation.sv
// Bench for relu_activation: plain, leaky (shift 3) and clamped variants
// driven in lockstep and compared against an arithmetic reference model.
module tb_relu_activation;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] val;

    logic        rdy [3];
    logic        ov  [3];
    logic [15:0] res [3];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic        m_valid;
    logic [15:0] m_res [3];

    always #5 clk = ~clk;

    relu_activation u_plain (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .val(val),
        .out_valid(ov[0]), .out_ready(out_ready), .result(res[0])
    );

    relu_activation #(.LEAKY_SHIFT(3)) u_leaky (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .val(val),
        .out_valid(ov[1]), .out_ready(out_ready), .result(res[1])
    );

    relu_activation #(.CLAMP_EN(1), .CLAMP_MAX(16'h0600)) u_clamp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .val(val),
        .out_valid(ov[2]), .out_ready(out_ready), .result(res[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: k=0 plain, k=1 leaky floor(x/8), k=2 clamp at 6.0
    function automatic logic [15:0] ref_f(input logic [15:0] d, input int k);
        int x;
        x = int'($signed(d));
        if (x < 0) begin
            if (k == 1) return 16'((x - 7) / 8);
            return 16'h0000;
        end
        if (k == 2 && x > 32'sh0600) return 16'h0600;
        return d;
    endfunction

    task automatic check_outputs(input string tag);
        for (int k = 0; k < 3; k++) begin
            check_eq({tag, "_valid"}, 32'(ov[k]), 32'(m_valid));
            check_eq({tag, "_result"}, 32'(res[k]), 32'(m_res[k]));
        end
    endtask

    // One clock cycle of stimulus; model advances by the handshake rules.
    task automatic step(input logic v, input logic [15:0] d, input logic ordy, input string tag);
        logic acc;
        @(negedge clk);
        in_valid  = v;
        val       = d;
        out_ready = ordy;
        #1;
        for (int k = 0; k < 3; k++)
            check_eq({tag, "_in_ready"}, 32'(rdy[k]), 32'(!m_valid || ordy));
        acc = v && (!m_valid || ordy);
        @(posedge clk);
        if (acc) begin
            m_valid = 1'b1;
            for (int k = 0; k < 3; k++) m_res[k] = ref_f(d, k);
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [15:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'h0600;
            3: return 16'h0000;
            4: return 16'hFFFF;
            5: return 16'h0601;
            default: return 16'($urandom());
        endcase
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        val       = 16'h0;
        m_valid   = 1'b0;
        for (int k = 0; k < 3; k++) m_res[k] = 16'h0;
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) check_eq("post_reset_in_ready", 32'(rdy[k]), 32'd1);

        // Single samples, including boundaries and parameter-variant points
        step(1'b1, 16'hF900, 1'b1, "neg7");
        step(1'b1, 16'h0300, 1'b1, "pos3");
        step(1'b1, 16'h0000, 1'b1, "zero");
        step(1'b1, 16'h8000, 1'b1, "minneg");
        step(1'b1, 16'h7FFF, 1'b1, "maxpos");
        step(1'b1, 16'h0700, 1'b1, "over_clamp");
        step(1'b1, 16'h0600, 1'b1, "at_clamp");
        step(1'b0, 16'h1234, 1'b1, "drain");
        step(1'b0, 16'h1234, 1'b1, "idle");

        // Back-to-back stream
        step(1'b1, 16'h0100, 1'b1, "stream0");
        step(1'b1, 16'hFF00, 1'b1, "stream1");
        step(1'b1, 16'h0200, 1'b1, "stream2");
        step(1'b1, 16'h8001, 1'b1, "stream3");
        step(1'b0, 16'h0000, 1'b1, "stream_drain");

        // Backpressure with val changing while stalled
        step(1'b1, 16'h0500, 1'b0, "bp_accept");
        step(1'b1, 16'h0111, 1'b0, "bp_hold0");
        step(1'b1, 16'hF222, 1'b0, "bp_hold1");
        step(1'b1, 16'h0333, 1'b0, "bp_hold2");
        step(1'b1, 16'h0440, 1'b1, "bp_release");
        step(1'b0, 16'h0000, 1'b1, "bp_drain");

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), pick_val(), 1'($urandom_range(0, 2) != 0), "rand");

        // Asynchronous reset while a stalled output is held
        step(1'b1, 16'h0450, 1'b0, "pre_rst");
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        m_valid = 1'b0;
        for (int k = 0; k < 3; k++) m_res[k] = 16'h0;
        check_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) check_eq("rst_release_in_ready", 32'(rdy[k]), 32'd1);
        step(1'b1, 16'hF900, 1'b1, "after_rst");
        step(1'b0, 16'h0000, 1'b1, "final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
